// File: rtl/lc3_ctrl_seq.sv
// LC-3 subset microsequencer: Moore FSM numbered after the LC-3 state diagram.
// Outputs are registered from the decode of the next state, so they always match `state`.
module lc3_ctrl_seq #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ir_op,
  input  logic       ben,
  input  logic       mem_ready,
  output logic       ld_mar,
  output logic       ld_mdr,
  output logic       ld_ir,
  output logic       ld_pc,
  output logic       ld_reg,
  output logic       ld_cc,
  output logic       ld_ben,
  output logic       gate_pc,
  output logic       gate_mdr,
  output logic       gate_alu,
  output logic       gate_marmux,
  output logic [1:0] pcmux,
  output logic       addr1mux,
  output logic [1:0] addr2mux,
  output logic [1:0] aluk,
  output logic       mem_en,
  output logic       r_w,
  output logic       illegal,
  output logic [5:0] state
);

  localparam int unsigned SW = 6;
  localparam int unsigned OW = 21;

  localparam logic [SW-1:0] S_BR    = 6'd0;
  localparam logic [SW-1:0] S_ADD   = 6'd1;
  localparam logic [SW-1:0] S_LD    = 6'd2;
  localparam logic [SW-1:0] S_AND   = 6'd5;
  localparam logic [SW-1:0] S_NOT   = 6'd9;
  localparam logic [SW-1:0] S_JMP   = 6'd12;
  localparam logic [SW-1:0] S_ILL   = 6'd13;
  localparam logic [SW-1:0] S_LEA   = 6'd14;
  localparam logic [SW-1:0] S_FETCH = 6'd18;
  localparam logic [SW-1:0] S_BRT   = 6'd22;
  localparam logic [SW-1:0] S_LDW   = 6'd25;
  localparam logic [SW-1:0] S_LDR   = 6'd27;
  localparam logic [SW-1:0] S_DEC   = 6'd32;
  localparam logic [SW-1:0] S_FWAIT = 6'd33;
  localparam logic [SW-1:0] S_IR    = 6'd35;
  localparam logic [SW-1:0] S_HALT  = 6'd63;

  // State-18 decode, loaded by reset
  localparam logic [OW-1:0] OUT_RST = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                       1'b1, 1'b0, 1'b0, 1'b0,
                                       2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

  logic [SW-1:0] state_q, state_d;
  logic [OW-1:0] out_q, out_d;

  logic       ld_mar_d, ld_mdr_d, ld_ir_d, ld_pc_d, ld_reg_d, ld_cc_d, ld_ben_d;
  logic       gate_pc_d, gate_mdr_d, gate_alu_d, gate_marmux_d;
  logic [1:0] pcmux_d, addr2mux_d, aluk_d;
  logic       addr1mux_d, mem_en_d, r_w_d, illegal_d;

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: state_d = mem_ready ? S_IR : S_FWAIT;
      S_IR:    state_d = S_DEC;
      S_DEC: begin
        case (ir_op)
          4'b0000: state_d = S_BR;
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          4'b1100: state_d = S_JMP;
          4'b1110: state_d = S_LEA;
          4'b0010: state_d = S_LD;
          default: state_d = S_ILL;
        endcase
      end
      S_BR:    state_d = ben ? S_BRT : S_FETCH;
      S_LD:    state_d = S_LDW;
      S_LDW:   state_d = mem_ready ? S_LDR : S_LDW;
      S_ILL:   state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
      S_HALT:  state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Control decode of the state being entered
  always_comb begin
    ld_mar_d      = 1'b0;
    ld_mdr_d      = 1'b0;
    ld_ir_d       = 1'b0;
    ld_pc_d       = 1'b0;
    ld_reg_d      = 1'b0;
    ld_cc_d       = 1'b0;
    ld_ben_d      = 1'b0;
    gate_pc_d     = 1'b0;
    gate_mdr_d    = 1'b0;
    gate_alu_d    = 1'b0;
    gate_marmux_d = 1'b0;
    pcmux_d       = 2'b00;
    addr1mux_d    = 1'b0;
    addr2mux_d    = 2'b00;
    aluk_d        = 2'b00;
    mem_en_d      = 1'b0;
    r_w_d         = 1'b0;
    illegal_d     = 1'b0;
    case (state_d)
      S_FETCH: begin
        ld_mar_d  = 1'b1;
        ld_pc_d   = 1'b1;
        gate_pc_d = 1'b1;
      end
      S_FWAIT, S_LDW: begin
        mem_en_d = 1'b1;
        ld_mdr_d = 1'b1;
      end
      S_IR: begin
        ld_ir_d    = 1'b1;
        gate_mdr_d = 1'b1;
      end
      S_DEC: ld_ben_d = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        ld_reg_d   = 1'b1;
        ld_cc_d    = 1'b1;
        gate_alu_d = 1'b1;
        aluk_d     = (state_d == S_AND) ? 2'b01 : ((state_d == S_NOT) ? 2'b10 : 2'b00);
      end
      S_BRT: begin
        ld_pc_d    = 1'b1;
        pcmux_d    = 2'b10;
        addr2mux_d = 2'b10;
      end
      S_JMP: begin
        ld_pc_d    = 1'b1;
        pcmux_d    = 2'b10;
        addr1mux_d = 1'b1;
      end
      S_LEA: begin
        ld_reg_d      = 1'b1;
        ld_cc_d       = 1'b1;
        gate_marmux_d = 1'b1;
        addr2mux_d    = 2'b10;
      end
      S_LD: begin
        ld_mar_d      = 1'b1;
        gate_marmux_d = 1'b1;
        addr2mux_d    = 2'b10;
      end
      S_LDR: begin
        ld_reg_d   = 1'b1;
        ld_cc_d    = 1'b1;
        gate_mdr_d = 1'b1;
      end
      S_ILL: illegal_d = 1'b1;
      default: ;
    endcase
  end

  assign out_d = {ld_mar_d, ld_mdr_d, ld_ir_d, ld_pc_d, ld_reg_d, ld_cc_d, ld_ben_d,
                  gate_pc_d, gate_mdr_d, gate_alu_d, gate_marmux_d,
                  pcmux_d, addr1mux_d, addr2mux_d, aluk_d, mem_en_d, r_w_d, illegal_d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign {ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben,
          gate_pc, gate_mdr, gate_alu, gate_marmux,
          pcmux, addr1mux, addr2mux, aluk, mem_en, r_w, illegal} = out_q;
  assign state = state_q;

endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Randomized bench for lc3_ctrl_seq: an instruction-level model expands each opcode
// into its expected state walk and per-state control word.
module tb_lc3_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] ir_op = 4'd0;
  logic       ben = 1'b0;
  logic       mem_ready = 1'b0;

  logic a_ld_mar, a_ld_mdr, a_ld_ir, a_ld_pc, a_ld_reg, a_ld_cc, a_ld_ben;
  logic a_gate_pc, a_gate_mdr, a_gate_alu, a_gate_marmux, a_addr1mux, a_mem_en, a_r_w, a_illegal;
  logic [1:0] a_pcmux, a_addr2mux, a_aluk;
  logic [5:0] a_state;
  logic b_ld_mar, b_ld_mdr, b_ld_ir, b_ld_pc, b_ld_reg, b_ld_cc, b_ld_ben;
  logic b_gate_pc, b_gate_mdr, b_gate_alu, b_gate_marmux, b_addr1mux, b_mem_en, b_r_w, b_illegal;
  logic [1:0] b_pcmux, b_addr2mux, b_aluk;
  logic [5:0] b_state;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit mr_q[$];
  logic [3:0] cur_op;
  bit cur_ben;

  lc3_ctrl_seq #(.ILLEGAL_HALT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .ir_op(ir_op), .ben(ben), .mem_ready(mem_ready),
    .ld_mar(a_ld_mar), .ld_mdr(a_ld_mdr), .ld_ir(a_ld_ir), .ld_pc(a_ld_pc), .ld_reg(a_ld_reg),
    .ld_cc(a_ld_cc), .ld_ben(a_ld_ben), .gate_pc(a_gate_pc), .gate_mdr(a_gate_mdr),
    .gate_alu(a_gate_alu), .gate_marmux(a_gate_marmux), .pcmux(a_pcmux), .addr1mux(a_addr1mux),
    .addr2mux(a_addr2mux), .aluk(a_aluk), .mem_en(a_mem_en), .r_w(a_r_w), .illegal(a_illegal),
    .state(a_state));

  lc3_ctrl_seq #(.ILLEGAL_HALT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .ir_op(ir_op), .ben(ben), .mem_ready(mem_ready),
    .ld_mar(b_ld_mar), .ld_mdr(b_ld_mdr), .ld_ir(b_ld_ir), .ld_pc(b_ld_pc), .ld_reg(b_ld_reg),
    .ld_cc(b_ld_cc), .ld_ben(b_ld_ben), .gate_pc(b_gate_pc), .gate_mdr(b_gate_mdr),
    .gate_alu(b_gate_alu), .gate_marmux(b_gate_marmux), .pcmux(b_pcmux), .addr1mux(b_addr1mux),
    .addr2mux(b_addr2mux), .aluk(b_aluk), .mem_en(b_mem_en), .r_w(b_r_w), .illegal(b_illegal),
    .state(b_state));

  always #5 clk = ~clk;

  // Control word bit positions (bench-local packing)
  localparam int LD_MAR = 20, LD_MDR = 19, LD_IR = 18, LD_PC = 17, LD_REG = 16, LD_CC = 15;
  localparam int LD_BEN = 14, G_PC = 13, G_MDR = 12, G_ALU = 11, G_MM = 10, A1 = 7;
  localparam int MEM_EN = 2, ILL = 0;

  function automatic logic [20:0] a_vec();
    return {a_ld_mar, a_ld_mdr, a_ld_ir, a_ld_pc, a_ld_reg, a_ld_cc, a_ld_ben,
            a_gate_pc, a_gate_mdr, a_gate_alu, a_gate_marmux,
            a_pcmux, a_addr1mux, a_addr2mux, a_aluk, a_mem_en, a_r_w, a_illegal};
  endfunction

  function automatic logic [20:0] b_vec();
    return {b_ld_mar, b_ld_mdr, b_ld_ir, b_ld_pc, b_ld_reg, b_ld_cc, b_ld_ben,
            b_gate_pc, b_gate_mdr, b_gate_alu, b_gate_marmux,
            b_pcmux, b_addr1mux, b_addr2mux, b_aluk, b_mem_en, b_r_w, b_illegal};
  endfunction

  // Expected control word per state number; -1 marks the illegal-opcode state
  function automatic logic [20:0] exp_vec(int s);
    logic [20:0] v;
    v = '0;
    case (s)
      18: begin v[LD_MAR] = 1; v[LD_PC] = 1; v[G_PC] = 1; end
      33, 25: begin v[MEM_EN] = 1; v[LD_MDR] = 1; end
      35: begin v[LD_IR] = 1; v[G_MDR] = 1; end
      32: v[LD_BEN] = 1;
      1, 5, 9: begin
        v[LD_REG] = 1; v[LD_CC] = 1; v[G_ALU] = 1;
        v[4:3] = (s == 5) ? 2'b01 : ((s == 9) ? 2'b10 : 2'b00);
      end
      22: begin v[LD_PC] = 1; v[9:8] = 2'b10; v[6:5] = 2'b10; end
      12: begin v[LD_PC] = 1; v[9:8] = 2'b10; v[A1] = 1; end
      14: begin v[LD_REG] = 1; v[LD_CC] = 1; v[G_MM] = 1; v[6:5] = 2'b10; end
      2:  begin v[LD_MAR] = 1; v[G_MM] = 1; v[6:5] = 2'b10; end
      27: begin v[LD_REG] = 1; v[LD_CC] = 1; v[G_MDR] = 1; end
      -1: v[ILL] = 1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Expand one instruction into its state walk (ending before the next fetch) and mem_ready plan
  task automatic plan(input logic [3:0] op, input bit b, input int w1, input int w2);
    exp_q.delete(); mr_q.delete();
    cur_op = op; cur_ben = b;
    exp_q.push_back(18); mr_q.push_back(1'($urandom));
    for (int k = 0; k < w1; k++) begin exp_q.push_back(33); mr_q.push_back(1'b0); end
    exp_q.push_back(33); mr_q.push_back(1'b1);
    exp_q.push_back(35); mr_q.push_back(1'($urandom));
    exp_q.push_back(32); mr_q.push_back(1'($urandom));
    case (op)
      4'b0001: exp_q.push_back(1);
      4'b0101: exp_q.push_back(5);
      4'b1001: exp_q.push_back(9);
      4'b1100: exp_q.push_back(12);
      4'b1110: exp_q.push_back(14);
      4'b0000: begin
        exp_q.push_back(0);
        if (b) begin mr_q.push_back(1'($urandom)); exp_q.push_back(22); end
      end
      4'b0010: begin
        exp_q.push_back(2); mr_q.push_back(1'($urandom));
        for (int k = 0; k < w2; k++) begin exp_q.push_back(25); mr_q.push_back(1'b0); end
        exp_q.push_back(25); mr_q.push_back(1'b1);
        exp_q.push_back(27);
      end
      default: exp_q.push_back(-1);
    endcase
    mr_q.push_back(1'($urandom));
  endtask

  // Drive inputs for plan entry i; ir_op and ben are only meaningful in 32 and 0
  task automatic drive(input int i);
    ir_op     = (exp_q[i] == 32) ? cur_op : 4'($urandom);
    ben       = (exp_q[i] == 0) ? cur_ben : 1'($urandom);
    mem_ready = mr_q[i];
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [3:0] pick_op();
    logic [3:0] ops [7] = '{4'b0000, 4'b0001, 4'b0101, 4'b1001, 4'b1100, 4'b1110, 4'b0010};
    if ($urandom_range(0, 9) == 0) return 4'($urandom);
    return ops[$urandom_range(0, 6)];
  endfunction

  task automatic test_reset();
    checks++;
    if (a_state !== 6'd18 || a_vec() !== exp_vec(18)) begin
      errors++; $display("FAIL reset_init: state=%0d ctl=%h want state=18 ctl=%h", a_state, a_vec(), exp_vec(18));
    end
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_state !== 6'd33) begin errors++; $display("FAIL reset_pre_wait: state=%0d want 33", a_state); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (a_state !== 6'd18 || a_vec() !== exp_vec(18) || b_state !== 6'd18) begin
      errors++; $display("FAIL reset_async: a=%0d ctl=%h b=%0d want 18 ctl=%h", a_state, a_vec(), b_state, exp_vec(18));
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add_wait();
    plan(4'b0001, 1'b0, 2, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (a_state !== 6'(exp_q[i])) begin errors++; $display("FAIL add_wait_state[%0d]: got %0d want %0d", i, a_state, exp_q[i]); end
      checks++;
      if (a_vec() !== exp_vec(exp_q[i])) begin errors++; $display("FAIL add_wait_ctl[%0d]: got %h want %h", i, a_vec(), exp_vec(exp_q[i])); end
      drive(i);
      @(negedge clk);
    end
    checks++;
    if (a_state !== 6'd18) begin errors++; $display("FAIL add_wait_end: got %0d want 18", a_state); end
  endtask

  task automatic test_br(input bit taken);
    plan(4'b0000, taken, taken ? 0 : 1, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (a_state !== 6'(exp_q[i])) begin errors++; $display("FAIL br%0d_state[%0d]: got %0d want %0d", taken, i, a_state, exp_q[i]); end
      checks++;
      if (a_vec() !== exp_vec(exp_q[i])) begin errors++; $display("FAIL br%0d_ctl[%0d]: got %h want %h", taken, i, a_vec(), exp_vec(exp_q[i])); end
      drive(i);
      @(negedge clk);
    end
    checks++;
    if (a_state !== 6'd18) begin errors++; $display("FAIL br%0d_end: got %0d want 18", taken, a_state); end
  endtask

  task automatic test_ld();
    plan(4'b0010, 1'b0, 0, 0);
    foreach (exp_q[i]) begin
      checks++;
      if (a_state !== 6'(exp_q[i])) begin errors++; $display("FAIL ld_state[%0d]: got %0d want %0d", i, a_state, exp_q[i]); end
      checks++;
      if (a_vec() !== exp_vec(exp_q[i])) begin errors++; $display("FAIL ld_ctl[%0d]: got %h want %h", i, a_vec(), exp_vec(exp_q[i])); end
      drive(i);
      @(negedge clk);
    end
    checks++;
    if (a_state !== 6'd18) begin errors++; $display("FAIL ld_end: got %0d want 18", a_state); end
  endtask

  task automatic test_illegal();
    plan(4'b1101, 1'b0, 1, 0);
    foreach (exp_q[i]) begin
      if (exp_q[i] >= 0) begin
        checks++;
        if (a_state !== 6'(exp_q[i]) || b_state !== 6'(exp_q[i])) begin
          errors++; $display("FAIL ill_state[%0d]: a=%0d b=%0d want %0d", i, a_state, b_state, exp_q[i]);
        end
      end
      checks++;
      if (a_vec() !== exp_vec(exp_q[i]) || b_vec() !== exp_vec(exp_q[i])) begin
        errors++; $display("FAIL ill_ctl[%0d]: a=%h b=%h want %h", i, a_vec(), b_vec(), exp_vec(exp_q[i]));
      end
      drive(i);
      @(negedge clk);
    end
    checks++;
    if (a_state !== 6'd18 || a_illegal !== 1'b0) begin errors++; $display("FAIL ill_return: state=%0d illegal=%b want 18/0", a_state, a_illegal); end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (b_state !== 6'd63 || b_vec() !== 21'd0) begin
        errors++; $display("FAIL halt_hold[%0d]: state=%0d ctl=%h want 63/0", c, b_state, b_vec());
      end
      ir_op = 4'($urandom); ben = 1'($urandom); mem_ready = 1'($urandom);
      @(negedge clk);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (b_state !== 6'd18 || b_vec() !== exp_vec(18)) begin errors++; $display("FAIL halt_reset: state=%0d ctl=%h want 18", b_state, b_vec()); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_ld();
    int stop;
    plan(4'b0010, 1'b0, 0, 4);
    stop = 0;
    foreach (exp_q[i]) if (stop == 0 && exp_q[i] == 25) stop = i + 2;
    for (int i = 0; i < stop; i++) begin
      checks++;
      if (a_state !== 6'(exp_q[i])) begin errors++; $display("FAIL rst25_state[%0d]: got %0d want %0d", i, a_state, exp_q[i]); end
      drive(i);
      @(negedge clk);
    end
    checks++;
    if (a_state !== 6'd25) begin errors++; $display("FAIL rst25_pre: got %0d want 25", a_state); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (a_state !== 6'd18 || a_vec() !== exp_vec(18)) begin errors++; $display("FAIL rst25_async: state=%0d ctl=%h want 18 %h", a_state, a_vec(), exp_vec(18)); end
    mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_state !== 6'd33 || a_mem_en !== 1'b1) begin errors++; $display("FAIL rst25_refetch: state=%0d mem_en=%b want 33/1", a_state, a_mem_en); end
    do_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      plan(pick_op(), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      foreach (exp_q[i]) begin
        if (exp_q[i] >= 0) begin
          checks++;
          if (a_state !== 6'(exp_q[i])) begin errors++; $display("FAIL rnd_state[%0d.%0d] op=%b: got %0d want %0d", n, i, cur_op, a_state, exp_q[i]); end
        end
        checks++;
        if (a_vec() !== exp_vec(exp_q[i])) begin errors++; $display("FAIL rnd_ctl[%0d.%0d] op=%b: got %h want %h", n, i, cur_op, a_vec(), exp_vec(exp_q[i])); end
        checks++;
        if ((a_ld_cc && a_ld_ben) || ($countones({a_gate_pc, a_gate_mdr, a_gate_alu, a_gate_marmux}) > 1)) begin
          errors++; $display("FAIL rnd_exclusive[%0d.%0d]: ld_cc=%b ld_ben=%b gates=%b%b%b%b", n, i, a_ld_cc, a_ld_ben,
                             a_gate_pc, a_gate_mdr, a_gate_alu, a_gate_marmux);
        end
        drive(i);
        @(negedge clk);
      end
    end
    checks++;
    if (a_state !== 6'd18) begin errors++; $display("FAIL rnd_end: got %0d want 18", a_state); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_add_wait();
    test_br(1'b1);
    test_br(1'b0);
    test_ld();
    test_illegal();
    test_reset_mid_ld();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3_ctrl_seq.md
Name: lc3_ctrl_seq

Overview:
- Microsequencer for a subset of the LC-3 ISA.
- Consumes the registered branch-enable bit produced by the condition-code block.
- Drives that block's load strobes: ld_cc and ld_ben.
- Drives the datapath load enables, gates, mux selects and memory handshake.
- Moore FSM: state numbers follow the LC-3 state diagram; all outputs decode from the current state only.

Parameters:
- ILLEGAL_HALT, 0, 1: unsupported opcode parks FSM in HALT until reset; 0: pulse illegal and return to fetch.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ir_op  in  4  IR[15:12], valid from state 32 onward.
- ben  in  1  registered branch enable from the condition-code block.
- mem_ready  in  1  memory R signal; read data valid when 1.
- ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg  out  1 each  datapath register load enables.
- ld_cc  out  1  load condition codes.
- ld_ben  out  1  load branch enable.
- gate_pc, gate_mdr, gate_alu, gate_marmux  out  1 each  bus drivers; at most one high per state.
- pcmux  out  2  00 PC+1, 01 bus, 10 address adder.
- addr1mux  out  1  0 PC, 1 BaseR.
- addr2mux  out  2  00 zero, 01 off6, 10 off9, 11 off11.
- aluk  out  2  00 ADD, 01 AND, 10 NOT, 11 PASSA.
- mem_en  out  1  memory enable.
- r_w  out  1  0 read (only reads in this subset).
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state  out  6  current state number, for debug.

Behaviour:
- Reset (rst=0, async): state=18. Outputs then equal the state-18 decode: ld_mar=1, ld_pc=1, gate_pc=1, pcmux=00. All other outputs 0, r_w=0.
- Every state lasts exactly one cycle, except 33 and 25, which hold while mem_ready=0.
- 18: MAR<-PC, PC<-PC+1 (ld_mar, ld_pc, gate_pc, pcmux=00) -> 33.
- 33: mem_en=1, ld_mdr=1 every cycle. Stay while mem_ready=0; -> 35 in the cycle mem_ready=1.
- 35: IR<-MDR (ld_ir, gate_mdr) -> 32.
- 32: ld_ben=1; dispatch on ir_op:
  - 0000 -> 0
  - 0001 -> 1
  - 0101 -> 5
  - 1001 -> 9
  - 1100 -> 12
  - 1110 -> 14
  - 0010 -> 2
  - anything else -> ILL
- 1/5/9: ld_reg, ld_cc, gate_alu; aluk = 00 / 01 / 10 respectively -> 18.
- 0: no strobes. ben=1 -> 22, else -> 18.
  - ben is sampled in state 0 and reflects the ld_ben issued in 32.
- 22: ld_pc, pcmux=10, addr1mux=0, addr2mux=10 -> 18.
- 12 (JMP): ld_pc, pcmux=10, addr1mux=1, addr2mux=00 -> 18.
- 14 (LEA): ld_reg, ld_cc, gate_marmux, addr1mux=0, addr2mux=10 -> 18. LEA sets CC.
- 2 (LD): ld_mar, gate_marmux, addr1mux=0, addr2mux=10 -> 25.
- 25: as 33, but exits to 27.
- 27: ld_reg, ld_cc, gate_mdr -> 18.
- ILL: illegal=1 for one cycle.
  - ILLEGAL_HALT=0: -> 18.
  - ILLEGAL_HALT=1: -> HALT (state 63). HALT has all outputs 0 and stays until reset.
- Encoding: unused state codes -> 18 on the next edge; outputs 0 while in one.
- ld_cc and ld_ben are never asserted in the same state.
- The CC written by instruction k is visible to instruction k+1's state-32 ld_ben, because 32 is at least 3 cycles after the setcc state.
- Reset mid-operation (any state, including a memory wait) returns to 18 immediately. No pending memory handshake is retained.
- mem_ready asserted outside 33/25 is ignored.

Test Plan:
- Reset: hold rst=0 in any state -> state=18, ld_mar=ld_pc=gate_pc=1, pcmux=00, illegal=0, mem_en=0.
- ADD fetch with 2 wait cycles: ir_op=0001, mem_ready low 2 cycles then high -> state sequence 18,33,33,33,35,32,1,18.
  - ld_cc=1 only in state 1; ld_ben=1 only in 32.
- BR taken: ir_op=0000, ben=1 in state 0 -> state 22 with ld_pc=1, pcmux=10, addr2mux=10, then 18.
- BR not taken: ir_op=0000, ben=0 in state 0 -> 0 then 18, with no ld_pc in state 0.
- LD: ir_op=0010, mem_ready=1 immediately -> sequence 18,33,35,32,2,25,27,18; ld_cc=1 and gate_mdr=1 in 27.
- Illegal/reset: ir_op=1101 with ILLEGAL_HALT=0 -> illegal pulse for one cycle, then 18.
  - ILLEGAL_HALT=1 -> state=63 held for 10 cycles, exits only on rst=0.
  - Reset mid-25 -> state=18 asynchronously.
